// File: rtl/fifo_reader_pkg.sv
// Shared occupancy type and constants for the FIFO pop-side stream reader.
package fifo_reader_pkg;
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO pop port plus downstream valid/ready stream, seen from the reader (master).
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry circular buffer: push side writes at tail, valid/ready side reads at head.
module skid_buf2
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output occ_t             occ_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    occ_t             occ_q, occ_d;
    logic             pop;

    // Gated during reset so nothing downstream can fire on stale contents.
    assign valid_o = (occ_q != OCC_EMPTY) & ~rst;
    assign data_o  = mem_q[head_q];
    assign occ_o   = occ_q;
    assign pop     = valid_o & ready_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) tail_d = ~tail_q;
        if (pop)    head_d = ~head_q;
        case ({push_i, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= OCC_EMPTY;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= data_i;
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO into a valid/ready stream; pop depends only on registered occupancy.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    fifo_stream_reader_if.master bus,
    output logic [CNT_W-1:0]    delivered_o,
    output logic                idle_o
);
    occ_t             occ;
    logic             pop_fire;
    logic             out_fire;
    logic [CNT_W-1:0] delivered_q, delivered_d;

    // out_ready is deliberately absent here: that keeps the ready path registered.
    assign pop_fire     = enable_i & ~bus.fifo_empty & (occ != OCC_FULL) & ~rst;
    assign bus.fifo_pop = pop_fire;

    skid_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pop_fire),
        .data_i  (bus.fifo_data),
        .valid_o (bus.out_valid),
        .ready_i (bus.out_ready),
        .data_o  (bus.out_data),
        .occ_o   (occ)
    );

    assign out_fire    = bus.out_valid & bus.out_ready;
    assign delivered_d = delivered_q + {{(CNT_W-1){1'b0}}, out_fire};

    always_ff @(posedge clk) begin
        if (rst) delivered_q <= '0;
        else     delivered_q <= delivered_d;
    end

    assign delivered_o = delivered_q;
    assign idle_o      = (occ == OCC_EMPTY) & bus.fifo_empty;
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Pop-side reader for shift_register_fifo. It drains the FIFO through its empty/pop/data_out interface and presents the data downstream as a valid/ready stream. A registered 2-entry output buffer keeps pop from depending combinationally on downstream ready, so the ready path is cut. The block never pops an empty FIFO, so the FIFO's pop/empty environmental constraint holds by construction.

Parameters:
WIDTH, 8, data width; must match the FIFO WIDTH.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  when 0, no new pops are issued; buffered data still drains
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO data_out; head word, valid whenever fifo_empty=0
fifo_pop  output  1  pop strobe to the FIFO
out_valid  output  1  downstream data valid
out_ready  input  1  downstream accept
out_data  output  WIDTH  downstream data
delivered  output  CNT_W  count of words accepted downstream (out_valid & out_ready)
idle  output  1  high when occ==0 and fifo_empty=1

Behaviour:
- Reset, synchronous and active-high, when rst=1 at a clock edge:
  - occ=0, head=0, tail=0, delivered=0.
  - During rst=1: fifo_pop=0 and out_valid=0 (both gated).
  - Buffer contents are don't-care.
  - A reset mid-stream drops buffered words. The FIFO is reset by the same rst.
- State:
  - 2-entry buffer mem[0:1].
  - 1-bit head and tail pointers.
  - 2-bit occupancy occ, range 0..2.
- pop_fire = fifo_pop = enable & ~fifo_empty & (occ != 2) & ~rst.
  - Registered occupancy only; out_ready does not appear in this path.
  - fifo_pop=1 with fifo_empty=1 is illegal and must never occur.
- Capture: on pop_fire, mem[tail] <= fifo_data and tail <= ~tail. Zero-latency capture: the word is in the buffer on the next cycle.
- Downstream side:
  - out_valid = (occ != 0).
  - out_data = mem[head].
  - out_fire = out_valid & out_ready. On out_fire: head <= ~head and delivered <= delivered + 1.
  - delivered wraps modulo 2^CNT_W; it does not saturate.
- Occupancy update:
  - occ <= occ + pop_fire - out_fire.
  - Simultaneous pop and accept leaves occ unchanged.
  - At occ==2, no pop is issued even if out_ready=1 that cycle. Sustained 1 word/cycle throughput is reached at occ==1.
- Latency: a word present at the FIFO head with occ==0 is popped in cycle N and appears on out_valid/out_data in cycle N+1.
- AXI-style stability: once out_valid=1, out_valid and out_data hold until out_fire.
- Order: words are delivered in exact FIFO pop order. No drops or duplicates except on reset.
- enable deasserted mid-stream: pops stop that same cycle; buffered words still drain downstream.
- idle is combinational from occ and fifo_empty.

Decomposition:
- Package fifo_reader_pkg holds the occupancy constants OCC_EMPTY=0, OCC_FULL=2 and the 2-bit occ_t typedef.
- One sub-module: skid_buf2, the 2-entry pointer/occupancy buffer with push/data_in and valid/ready/data_out.
- The top module adds pop generation, enable gating, the delivered counter and idle.

Test Plan:
- FIFO preloaded with 0x11, 0x22, 0x33; out_ready=1 constant. Expect fifo_pop high on 3 consecutive cycles, out_data=0x11/0x22/0x33 on the following 3 cycles, and delivered=3 at the end.
- out_ready=0 with FIFO holding 4 words. Expect exactly 2 pops, then fifo_pop=0 with occ=2 and out_data=first word held stable. Raising out_ready delivers all 4 words in order.
- FIFO empty, out_ready=1. Expect fifo_pop=0 every cycle and out_valid=0. Push 0xA5: it is popped the next cycle and appears on out_data one cycle later.
- enable=0 with 2 words buffered and 2 in the FIFO. Expect the 2 buffered words delivered, no pops, then idle=0 until enable=1 drains the rest.
- rst asserted while occ=2. Next cycle: out_valid=0, delivered=0, fifo_pop=0. After release, a newly pushed word 0x5C is delivered correctly.
- CNT_W=4: stream 17 words. Expect delivered to wrap to 1. Throughout, the formal property fifo_pop -> ~fifo_empty holds every cycle.
